id_exe_pipeline_reg: RTL and testbench

ID/EXE pipeline boundary for the five-stage MIPS core. It latches the decoded control word, register-file operands, destination register and the 32-bit sign-extended immediate produced in ID. It detects load-use hazards against the instruction currently held in EXE and inserts a bubble when one is found. It also counts inserted bubbles for debug.

---
 rtl/id_exe_pipeline_reg_pkg.sv | 32 +++
 rtl/id_exe_pipeline_reg_load_use_detect.sv | 39 +++
 rtl/id_exe_pipeline_reg.sv | 134 +++++++++++++
 tb/tb_id_exe_pipeline_reg.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/id_exe_pipeline_reg_pkg.sv
// ---------------------------------------------------------------------------
// id_exe_pipeline_reg_pkg
// Types and constants shared by the ID/EXE boundary, the ALU and the control
// unit of the five-stage MIPS core.
//   ctrl_t  : decoded control word carried from ID into EXE
//   BUBBLE  : all-zero control word (a NOP that writes nothing)
//   ALU_*   : ALU operation codes driven on aluc
// ---------------------------------------------------------------------------
package id_exe_pipeline_reg_pkg;

    typedef struct packed {
        logic       valid;
        logic       wreg;
        logic       m2reg;
        logic       wmem;
        logic       aluimm;
        logic [3:0] aluc;
    } ctrl_t;

    localparam ctrl_t BUBBLE = '0;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_AND = 4'b0001;
    localparam logic [3:0] ALU_XOR = 4'b0010;
    localparam logic [3:0] ALU_SLL = 4'b0011;
    localparam logic [3:0] ALU_SUB = 4'b0100;
    localparam logic [3:0] ALU_OR  = 4'b0101;
    localparam logic [3:0] ALU_LUI = 4'b0110;
    localparam logic [3:0] ALU_SRL = 4'b0111;
    localparam logic [3:0] ALU_SRA = 4'b1111;

endpackage : id_exe_pipeline_reg_pkg

// File: rtl/id_exe_pipeline_reg_load_use_detect.sv
// ---------------------------------------------------------------------------
// load_use_detect
// Combinational load-use hazard detector. Flags the instruction in ID when it
// reads the register that the load currently in EXE will write.
//   exe_valid/exe_wreg/exe_m2reg/exe_dest : state of the instruction in EXE
//   id_valid/id_rs/id_rt/id_use_rt        : source usage of the ID instruction
//   stall                                 : freeze PC and IF/ID, bubble EXE
// ---------------------------------------------------------------------------
module load_use_detect #(
    parameter int REG_W = 5
) (
    input  logic             exe_valid,
    input  logic             exe_wreg,
    input  logic             exe_m2reg,
    input  logic [REG_W-1:0] exe_dest,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rt,
    output logic             stall
);

    logic exe_is_load;
    logic src_hit;

    always_comb begin
        // NOTE: every signal driven here gets a value on every path, so no
        // latch can be inferred.
        exe_is_load = 1'b0;
        src_hit     = 1'b0;
        stall       = 1'b0;

        // $0 is hardwired to zero, so a load targeting it is never a hazard.
        exe_is_load = exe_valid & exe_wreg & exe_m2reg & (exe_dest != '0);
        src_hit     = (exe_dest == id_rs) | (id_use_rt & (exe_dest == id_rt));
        stall       = id_valid & exe_is_load & src_hit;
    end

endmodule : load_use_detect

// File: rtl/id_exe_pipeline_reg.sv
// ---------------------------------------------------------------------------
// id_exe_pipeline_reg
// ID/EXE pipeline register with load-use bubble insertion and a saturating
// bubble counter for debug.
//   clk, rst            : rising-edge clock, asynchronous active-high reset
//   id_*                : decoded instruction from ID
//   flush               : squash the instruction entering EXE
//   stall               : combinational load-use stall to PC and IF/ID
//   exe_*               : registered instruction presented to EXE
//   bubble_cnt          : load-use bubbles inserted since reset (saturating)
// ---------------------------------------------------------------------------
module id_exe_pipeline_reg
    import id_exe_pipeline_reg_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic              id_wreg,
    input  logic              id_m2reg,
    input  logic              id_wmem,
    input  logic              id_aluimm,
    input  logic [3:0]        id_aluc,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic              id_use_rt,
    input  logic [REG_W-1:0]  id_dest,
    input  logic [DATA_W-1:0] id_qa,
    input  logic [DATA_W-1:0] id_qb,
    input  logic [DATA_W-1:0] id_imm32,
    input  logic              flush,
    output logic              stall,
    output logic              exe_valid,
    output logic              exe_wreg,
    output logic              exe_m2reg,
    output logic              exe_wmem,
    output logic              exe_aluimm,
    output logic [3:0]        exe_aluc,
    output logic [REG_W-1:0]  exe_dest,
    output logic [DATA_W-1:0] exe_qa,
    output logic [DATA_W-1:0] exe_qb,
    output logic [DATA_W-1:0] exe_imm32,
    output logic [CNT_W-1:0]  bubble_cnt
);

    ctrl_t             ctrl_d,  ctrl_q;
    logic [REG_W-1:0]  dest_d,  dest_q;
    logic [DATA_W-1:0] qa_d,    qa_q;
    logic [DATA_W-1:0] qb_d,    qb_q;
    logic [DATA_W-1:0] imm_d,   imm_q;
    logic [CNT_W-1:0]  cnt_d,   cnt_q;
    ctrl_t             id_ctrl;

    assign id_ctrl = '{valid:  id_valid,
                       wreg:   id_wreg,
                       m2reg:  id_m2reg,
                       wmem:   id_wmem,
                       aluimm: id_aluimm,
                       aluc:   id_aluc};

    // stall depends only on id_* inputs and registered EXE state, so there
    // is no combinational loop through it.
    load_use_detect #(.REG_W(REG_W)) u_load_use_detect (
        .exe_valid (ctrl_q.valid),
        .exe_wreg  (ctrl_q.wreg),
        .exe_m2reg (ctrl_q.m2reg),
        .exe_dest  (dest_q),
        .id_valid  (id_valid),
        .id_rs     (id_rs),
        .id_rt     (id_rt),
        .id_use_rt (id_use_rt),
        .stall     (stall)
    );

    always_comb begin
        ctrl_d = id_ctrl;
        dest_d = id_dest;
        qa_d   = id_qa;
        qb_d   = id_qb;
        imm_d  = id_imm32;
        cnt_d  = cnt_q;

        if (flush || stall) begin
            // Bubble: control zeroed, data fields simply hold (don't-care).
            ctrl_d = BUBBLE;
            dest_d = '0;
            qa_d   = qa_q;
            qb_d   = qb_q;
            imm_d  = imm_q;
        end

        // A flushed slot is squashed for control-flow reasons, not counted
        // as a load-use bubble.
        if (stall && !flush && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q <= BUBBLE;
            dest_q <= '0;
            qa_q   <= '0;
            qb_q   <= '0;
            imm_q  <= '0;
            cnt_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling the
            // pre-edge values regardless of statement order.
            ctrl_q <= ctrl_d;
            dest_q <= dest_d;
            qa_q   <= qa_d;
            qb_q   <= qb_d;
            imm_q  <= imm_d;
            cnt_q  <= cnt_d;
        end
    end

    assign exe_valid  = ctrl_q.valid;
    assign exe_wreg   = ctrl_q.wreg;
    assign exe_m2reg  = ctrl_q.m2reg;
    assign exe_wmem   = ctrl_q.wmem;
    assign exe_aluimm = ctrl_q.aluimm;
    assign exe_aluc   = ctrl_q.aluc;
    assign exe_dest   = dest_q;
    assign exe_qa     = qa_q;
    assign exe_qb     = qb_q;
    assign exe_imm32  = imm_q;
    assign bubble_cnt = cnt_q;

endmodule : id_exe_pipeline_reg

// File: tb/tb_id_exe_pipeline_reg.sv
module tb_id_exe_pipeline_reg;
    import id_exe_pipeline_reg_pkg::*;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int CNT_W  = 16;
    localparam int SCNT_W = 2;

    logic clk = 1'b0;
    logic rst;
    logic id_valid, id_wreg, id_m2reg, id_wmem, id_aluimm, id_use_rt, flush;
    logic [3:0]        id_aluc;
    logic [REG_W-1:0]  id_rs, id_rt, id_dest;
    logic [DATA_W-1:0] id_qa, id_qb, id_imm32;

    logic              stall, exe_valid, exe_wreg, exe_m2reg, exe_wmem, exe_aluimm;
    logic [3:0]        exe_aluc;
    logic [REG_W-1:0]  exe_dest;
    logic [DATA_W-1:0] exe_qa, exe_qb, exe_imm32;
    logic [CNT_W-1:0]  bubble_cnt;

    logic              s_stall, s_valid, s_wreg, s_m2reg, s_wmem, s_aluimm;
    logic [3:0]        s_aluc;
    logic [REG_W-1:0]  s_dest;
    logic [DATA_W-1:0] s_qa, s_qb, s_imm32;
    logic [SCNT_W-1:0] s_bubble_cnt;

    always #5 clk = ~clk;

    id_exe_pipeline_reg #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_wreg(id_wreg),
        .id_m2reg(id_m2reg), .id_wmem(id_wmem), .id_aluimm(id_aluimm),
        .id_aluc(id_aluc), .id_rs(id_rs), .id_rt(id_rt), .id_use_rt(id_use_rt),
        .id_dest(id_dest), .id_qa(id_qa), .id_qb(id_qb), .id_imm32(id_imm32),
        .flush(flush), .stall(stall), .exe_valid(exe_valid), .exe_wreg(exe_wreg),
        .exe_m2reg(exe_m2reg), .exe_wmem(exe_wmem), .exe_aluimm(exe_aluimm),
        .exe_aluc(exe_aluc), .exe_dest(exe_dest), .exe_qa(exe_qa), .exe_qb(exe_qb),
        .exe_imm32(exe_imm32), .bubble_cnt(bubble_cnt)
    );

    // Narrow-counter instance on the same inputs to exercise saturation.
    id_exe_pipeline_reg #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(SCNT_W)) dut_sat (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_wreg(id_wreg),
        .id_m2reg(id_m2reg), .id_wmem(id_wmem), .id_aluimm(id_aluimm),
        .id_aluc(id_aluc), .id_rs(id_rs), .id_rt(id_rt), .id_use_rt(id_use_rt),
        .id_dest(id_dest), .id_qa(id_qa), .id_qb(id_qb), .id_imm32(id_imm32),
        .flush(flush), .stall(s_stall), .exe_valid(s_valid), .exe_wreg(s_wreg),
        .exe_m2reg(s_m2reg), .exe_wmem(s_wmem), .exe_aluimm(s_aluimm),
        .exe_aluc(s_aluc), .exe_dest(s_dest), .exe_qa(s_qa), .exe_qb(s_qb),
        .exe_imm32(s_imm32), .bubble_cnt(s_bubble_cnt)
    );

    typedef struct {
        string       name;
        logic        valid, wreg, m2reg, wmem, aluimm;
        logic [3:0]  aluc;
        logic [4:0]  rs, rt;
        logic        use_rt;
        logic [4:0]  dest;
        logic [31:0] qa, qb, imm;
        logic        flush;
        logic        exp_stall;
    } vec_t;

    typedef struct {
        string       name;
        ctrl_t       ctrl;
        logic [4:0]  dest;
        logic [31:0] qa, qb, imm;
        logic [15:0] cnt;
        logic [1:0]  scnt;
    } exp_t;

    exp_t q[$];
    exp_t model;
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name,
                                input logic valid, wreg, m2reg, wmem, aluimm,
                                input logic [3:0] aluc,
                                input logic [4:0] rs, rt,
                                input logic use_rt,
                                input logic [4:0] dest,
                                input logic [31:0] qa, qb, imm,
                                input logic fl, st);
        vec_t v;
        v.name = name; v.valid = valid; v.wreg = wreg; v.m2reg = m2reg;
        v.wmem = wmem; v.aluimm = aluimm; v.aluc = aluc; v.rs = rs; v.rt = rt;
        v.use_rt = use_rt; v.dest = dest; v.qa = qa; v.qb = qb; v.imm = imm;
        v.flush = fl; v.exp_stall = st;
        return v;
    endfunction

    // Drive one ID vector, check the hand-computed stall, and push the
    // expected EXE contents after the next edge.
    task automatic apply(input vec_t v);
        @(negedge clk);
        id_valid = v.valid; id_wreg = v.wreg; id_m2reg = v.m2reg; id_wmem = v.wmem;
        id_aluimm = v.aluimm; id_aluc = v.aluc; id_rs = v.rs; id_rt = v.rt;
        id_use_rt = v.use_rt; id_dest = v.dest; id_qa = v.qa; id_qb = v.qb;
        id_imm32 = v.imm; flush = v.flush;
        #1;
        check({v.name, " stall"}, 64'(stall), 64'(v.exp_stall));
        check({v.name, " sat stall"}, 64'(s_stall), 64'(v.exp_stall));
        model.name = v.name;
        if (v.flush || v.exp_stall) begin
            model.ctrl = '0;
            model.dest = '0;
        end else begin
            model.ctrl = '{valid: v.valid, wreg: v.wreg, m2reg: v.m2reg,
                           wmem: v.wmem, aluimm: v.aluimm, aluc: v.aluc};
            model.dest = v.dest;
            model.qa = v.qa; model.qb = v.qb; model.imm = v.imm;
        end
        if (v.exp_stall && !v.flush) begin
            model.cnt  = model.cnt + 16'd1;
            model.scnt = (model.scnt == 2'd3) ? 2'd3 : model.scnt + 2'd1;
        end
        q.push_back(model);
    endtask

    // Monitor: after every edge, compare EXE outputs against the oldest entry.
    always @(posedge clk) begin
        #1;
        if (!rst && q.size() != 0) begin
            mon_e = q.pop_front();
            check({mon_e.name, " exe_ctrl"},
                  64'({exe_valid, exe_wreg, exe_m2reg, exe_wmem, exe_aluimm, exe_aluc}),
                  64'(mon_e.ctrl));
            check({mon_e.name, " exe_dest"}, 64'(exe_dest), 64'(mon_e.dest));
            check({mon_e.name, " bubble_cnt"}, 64'(bubble_cnt), 64'(mon_e.cnt));
            check({mon_e.name, " sat bubble_cnt"}, 64'(s_bubble_cnt), 64'(mon_e.scnt));
            if (mon_e.ctrl.valid) begin
                check({mon_e.name, " exe_qa"}, 64'(exe_qa), 64'(mon_e.qa));
                check({mon_e.name, " exe_qb"}, 64'(exe_qb), 64'(mon_e.qb));
                check({mon_e.name, " exe_imm32"}, 64'(exe_imm32), 64'(mon_e.imm));
            end
        end
    end

    logic [1:0] sat_exp [5];

    initial begin
        sat_exp[0] = 2'd1; sat_exp[1] = 2'd2; sat_exp[2] = 2'd3;
        sat_exp[3] = 2'd3; sat_exp[4] = 2'd3;
        model = '{name: "", ctrl: '0, dest: '0, qa: '0, qb: '0, imm: '0, cnt: '0, scnt: '0};

        rst = 1'b1;
        id_valid = 0; id_wreg = 0; id_m2reg = 0; id_wmem = 0; id_aluimm = 0;
        id_aluc = '0; id_rs = '0; id_rt = '0; id_use_rt = 0; id_dest = '0;
        id_qa = '0; id_qb = '0; id_imm32 = '0; flush = 0;
        repeat (2) @(negedge clk);
        check("reset exe_valid", 64'(exe_valid), 64'd0);
        check("reset bubble_cnt", 64'(bubble_cnt), 64'd0);
        rst = 1'b0;

        //          name           v  w  m2 wm ai aluc     rs  rt ur dst qa            qb            imm           fl st
        apply(mk("pass",         1, 1, 0, 0, 0, 4'b0010, 1,  2, 1, 5,  32'h12345678, 32'hCAFEF00D, 32'hFFFF8000, 0, 0));
        apply(mk("lw8",          1, 1, 1, 0, 1, ALU_ADD, 29, 8, 0, 8,  32'h00001000, 32'h0,        32'h4,        0, 0));
        apply(mk("add_hazard",   1, 1, 0, 0, 0, ALU_ADD, 8,  9, 1, 10, 32'hAAAA0001, 32'hBBBB0002, 32'h0,        0, 1));
        apply(mk("add_go",       1, 1, 0, 0, 0, ALU_ADD, 8,  9, 1, 10, 32'hAAAA0001, 32'hBBBB0002, 32'h0,        0, 0));
        apply(mk("lw0",          1, 1, 1, 0, 1, ALU_ADD, 29, 0, 0, 0,  32'h00001000, 32'h0,        32'h8,        0, 0));
        apply(mk("add_r0",       1, 1, 0, 0, 0, ALU_SUB, 0,  0, 1, 11, 32'h0,        32'h0,        32'h0,        0, 0));
        apply(mk("lw8b",         1, 1, 1, 0, 1, ALU_ADD, 29, 8, 0, 8,  32'h00002000, 32'h0,        32'hC,        0, 0));
        apply(mk("addi_rt",      1, 1, 0, 0, 1, ALU_ADD, 3,  8, 0, 8,  32'h00000033, 32'h0,        32'h10,       0, 0));
        apply(mk("nonload_dep",  1, 1, 0, 0, 0, ALU_OR,  8,  9, 1, 12, 32'h0F0F0F0F, 32'hF0F0F0F0, 32'h0,        0, 0));
        apply(mk("lw8c",         1, 1, 1, 0, 1, ALU_ADD, 29, 8, 0, 8,  32'h00003000, 32'h0,        32'h14,       0, 0));
        apply(mk("sw_rt_hazard", 1, 0, 0, 1, 1, ALU_ADD, 4,  8, 1, 0,  32'h00000400, 32'h00000808, 32'h18,       0, 1));
        apply(mk("sw_go",        1, 0, 0, 1, 1, ALU_ADD, 4,  8, 1, 0,  32'h00000400, 32'h00000808, 32'h18,       0, 0));
        apply(mk("lw8d",         1, 1, 1, 0, 1, ALU_ADD, 29, 8, 0, 8,  32'h00004000, 32'h0,        32'h1C,       0, 0));
        apply(mk("flush_hazard", 1, 1, 0, 0, 0, ALU_ADD, 8,  9, 1, 10, 32'h1,        32'h2,        32'h0,        1, 1));
        apply(mk("lw7",          1, 1, 1, 0, 1, ALU_ADD, 29, 7, 0, 7,  32'h00005000, 32'h0,        32'h20,       0, 0));
        apply(mk("lw8_b2b",      1, 1, 1, 0, 1, ALU_ADD, 29, 8, 0, 8,  32'h00005000, 32'h0,        32'h24,       0, 0));
        apply(mk("add_dep_lw7",  1, 1, 0, 0, 0, ALU_AND, 7,  9, 1, 13, 32'h77777777, 32'h99999999, 32'h0,        0, 0));
        apply(mk("lw8f",         1, 1, 1, 0, 1, ALU_ADD, 29, 8, 0, 8,  32'h00006000, 32'h0,        32'h28,       0, 0));
        apply(mk("invalid_dep",  0, 1, 0, 0, 0, ALU_ADD, 8,  8, 1, 14, 32'h0,        32'h0,        32'h0,        0, 0));
        apply(mk("final_wr",     1, 1, 0, 0, 0, ALU_XOR, 1,  2, 1, 3,  32'hDEADBEEF, 32'h01234567, 32'h00007FFF, 0, 0));

        // Asynchronous reset in mid-cycle with a writing instruction in EXE.
        @(posedge clk);
        #3;
        check("pre-reset exe_wreg", 64'(exe_wreg), 64'd1);
        rst = 1'b1;
        #1;
        check("async rst ctrl",
              64'({exe_valid, exe_wreg, exe_m2reg, exe_wmem, exe_aluimm, exe_aluc}), 64'd0);
        check("async rst dest", 64'(exe_dest), 64'd0);
        check("async rst data", 64'({exe_qa, exe_qb}) | 64'(exe_imm32), 64'd0);
        check("async rst bubble_cnt", 64'(bubble_cnt), 64'd0);
        check("async rst sat bubble_cnt", 64'(s_bubble_cnt), 64'd0);
        check("async rst stall", 64'(stall), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        model = '{name: "", ctrl: '0, dest: '0, qa: '0, qb: '0, imm: '0, cnt: '0, scnt: '0};

        // Five load-use hazards: the 2-bit counter must stick at 3.
        for (int i = 0; i < 5; i++) begin
            apply(mk("sat_lw8", 1, 1, 1, 0, 1, ALU_ADD, 29, 8, 0, 8, 32'h00007000, 32'h0, 32'h30, 0, 0));
            apply(mk("sat_add", 1, 1, 0, 0, 0, ALU_ADD, 8,  9, 1, 10, 32'h5, 32'h6, 32'h0, 0, 1));
            @(posedge clk);
            #2;
            check($sformatf("saturation step %0d", i), 64'(s_bubble_cnt), 64'(sat_exp[i]));
        end
        check("wide counter after 5 hazards", 64'(bubble_cnt), 64'd5);

        apply(mk("idle", 0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0));
        @(posedge clk);
        #3;
        if (q.size() != 0) check("scoreboard drained", 64'(q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_id_exe_pipeline_reg
